tdc_window_comparator: RTL
==========================

Name: tdc_window_comparator

Overview:
- Parametrised, pipelined successor to the team's 1-bit equality comparator, used in the TDC back end.
- Compares each incoming WIDTH-bit timestamp/code against programmable low/high bounds and produces eq/lt/gt/match flags with a valid strobe.
- Counts matching samples and raises a sticky trigger after CONSEC consecutive valid matches.
- Sits between the TDC encoder output and the event/histogram logic.

Parameters:
WIDTH, 16, bit width of sample and bounds (unsigned)
CNT_W, 8, width of saturating hit counter
CONSEC, 3, consecutive valid matches required to fire trigger (>=1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  sample qualifier
in_a  input  WIDTH  sample (unsigned)
lo_bound  input  WIDTH  low bound / equality reference
hi_bound  input  WIDTH  high bound
mode  input  2  00 equal, 01 inside window, 10 outside window, 11 threshold
clr  input  1  synchronous clear of counter and trigger FSM
out_valid  output  1  result qualifier
eq  output  1  in_a == lo_bound
lt  output  1  in_a < lo_bound
gt  output  1  in_a > hi_bound
match  output  1  mode-selected result
hit_cnt  output  CNT_W  saturating count of valid matches
trigger  output  1  sticky; set after CONSEC consecutive matches

Behaviour:
- Reset (async, rst=1): all pipeline valids, out_valid, eq, lt, gt, match, trigger = 0; hit_cnt = 0; FSM = IDLE. Release is synchronous to clk.
- Stage 1: registers in_a, lo_bound, hi_bound, mode and in_valid on every edge. Bounds and mode are sampled with the data, so changing them mid-stream affects only later samples.
- Stage 2: computes comparisons on the stage-1 registers and registers all flags.
- Latency: in_valid at edge N produces out_valid at edge N+2. Throughput is one sample per cycle with no backpressure.
- Flags are updated only when the stage-1 valid is 1. Otherwise they hold their last value and out_valid = 0.
- Match by mode:
  - 00: a==lo
  - 01: lo<=a<=hi (inclusive)
  - 10: NOT(lo<=a<=hi)
  - 11: a>=lo, hi ignored
- lo > hi: mode 01 gives match=0 for every a; mode 10 gives match=1 for every a; gt still means a>hi.
- Comparisons are unsigned and full-width. No wrap-around handling.
- hit_cnt: increments on the same edge that registers a valid match. It saturates at 2^CNT_W-1 and holds there.
- Trigger FSM, advancing only on valid stage-2 results:
  - IDLE: on a match go to COUNT with run=1, or straight to FIRED if CONSEC=1.
  - COUNT: a match increments run; reaching run==CONSEC goes to FIRED. A non-match returns to IDLE with run=0.
  - FIRED: trigger=1, held regardless of further samples until clr or rst.
  - Bubble cycles (valid=0) neither break nor extend a run.
- trigger rises on the same edge that out_valid/match present the CONSEC-th consecutive match.
- clr (synchronous): next edge sets hit_cnt=0, FSM=IDLE, run=0, trigger=0. It does not flush the pipeline, and flags/out_valid continue normally.
- clr on the same edge as a valid match: clr wins; hit_cnt=0 and run=0, and that match is not counted.
- rst mid-stream: in-flight samples are discarded; no out_valid for them after release.

Test Plan:
- Reset/latency (WIDTH=16): rst pulse, then in_a=0x0100, lo=0x0100, mode=00, in_valid one cycle -> out_valid exactly 2 cycles later with eq=1, match=1, lt=0, hit_cnt=1; all outputs 0 during rst.
- Window inclusive: lo=10, hi=20, mode=01, stream a=9,10,20,21 -> match=0,1,1,0; lt=1,0,0,0; gt=0,0,0,1; hit_cnt ends at 2. Repeat with mode=10 -> match=1,0,0,1.
- Consecutive trigger (CONSEC=3), mode=11, lo=5: samples 6,7 then bubble, then 2,8,9,10 -> no trigger after 6,7,bubble; 2 resets run; trigger rises with the out_valid of 10 and stays 1 through a following sample 0.
- Saturation (CNT_W=4): 20 back-to-back matches -> hit_cnt stops at 15. clr on the same cycle as a valid match -> hit_cnt=0, trigger=0.
- Inverted bounds: lo=30, hi=10, a=20 -> mode01 match=0, mode10 match=1, gt=1, lt=1.
- Async reset mid-stream: assert rst between two edges while 2 samples are in flight -> outputs clear immediately; no out_valid after release until new in_valid+2.

Source files
------------

// File: rtl/tdc_window_comparator.sv
// tdc_window_comparator
//
// Two-stage pipelined window comparator for the TDC back end. Each sample is
// compared against programmable low/high bounds. The result is presented as
// eq/lt/gt/match flags with a valid strobe. A saturating counter tracks valid
// matches. A small FSM raises a sticky trigger after CONSEC consecutive valid
// matches.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   sample qualifier
//   in_a       sample (unsigned, WIDTH bits)
//   lo_bound   low bound; also the equality reference
//   hi_bound   high bound
//   mode       00 equal, 01 inside window, 10 outside window, 11 threshold (a >= lo)
//   clr        synchronous clear of hit counter and trigger FSM (pipeline untouched)
//   out_valid  result qualifier, two edges after in_valid
//   eq/lt/gt   in_a == lo, in_a < lo, in_a > hi (held when no valid result)
//   match      mode-selected result (held when no valid result)
//   hit_cnt    saturating count of valid matches
//   trigger    sticky; set after CONSEC consecutive valid matches
module tdc_window_comparator #(
    parameter int WIDTH  = 16,
    parameter int CNT_W  = 8,
    parameter int CONSEC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] lo_bound,
    input  logic [WIDTH-1:0] hi_bound,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic             out_valid,
    output logic             eq,
    output logic             lt,
    output logic             gt,
    output logic             match,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             trigger
);

    localparam int RUN_W = $clog2(CONSEC + 1);

    localparam logic [1:0] MODE_EQ      = 2'b00;
    localparam logic [1:0] MODE_INSIDE  = 2'b01;
    localparam logic [1:0] MODE_OUTSIDE = 2'b10;
    localparam logic [1:0] MODE_THRESH  = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_FIRED = 2'd2;

    // Stage 1: sample, bounds and mode captured together.
    logic             v1_d,    v1_q;
    logic [WIDTH-1:0] a1_d,    a1_q;
    logic [WIDTH-1:0] lo1_d,   lo1_q;
    logic [WIDTH-1:0] hi1_d,   hi1_q;
    logic [1:0]       mode1_d, mode1_q;

    // Stage 2: registered flags, counter and trigger FSM.
    logic             out_valid_d, out_valid_q;
    logic             eq_d,        eq_q;
    logic             lt_d,        lt_q;
    logic             gt_d,        gt_q;
    logic             match_d,     match_q;
    logic [CNT_W-1:0] hit_cnt_d,   hit_cnt_q;
    logic [1:0]       state_d,     state_q;
    logic [RUN_W-1:0] run_d,       run_q;

    // Combinational comparison results on the stage-1 registers.
    logic cmp_eq, cmp_lt, cmp_gt, in_win, cmp_match;

    always_comb begin
        v1_d    = in_valid;
        a1_d    = in_a;
        lo1_d   = lo_bound;
        hi1_d   = hi_bound;
        mode1_d = mode;
    end

    always_comb begin
        cmp_eq = (a1_q == lo1_q);
        cmp_lt = (a1_q <  lo1_q);
        cmp_gt = (a1_q >  hi1_q);
        // With lo > hi this is never true, so inside never matches and outside always does.
        in_win = !cmp_lt && (a1_q <= hi1_q);
        unique case (mode1_q)
            MODE_EQ:      cmp_match = cmp_eq;
            MODE_INSIDE:  cmp_match = in_win;
            MODE_OUTSIDE: cmp_match = !in_win;
            MODE_THRESH:  cmp_match = !cmp_lt;
            default:      cmp_match = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        out_valid_d = v1_q;
        eq_d        = eq_q;
        lt_d        = lt_q;
        gt_d        = gt_q;
        match_d     = match_q;
        hit_cnt_d   = hit_cnt_q;
        state_d     = state_q;
        run_d       = run_q;

        // Flags hold their last value across bubbles.
        if (v1_q) begin
            eq_d    = cmp_eq;
            lt_d    = cmp_lt;
            gt_d    = cmp_gt;
            match_d = cmp_match;
        end

        if (clr) begin
            // clr beats a match arriving on the same edge: that match is not counted.
            hit_cnt_d = '0;
            state_d   = ST_IDLE;
            run_d     = '0;
        end else if (v1_q) begin
            if (cmp_match && (hit_cnt_q != {CNT_W{1'b1}})) begin
                hit_cnt_d = hit_cnt_q + 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (cmp_match) begin
                        run_d   = RUN_W'(1);
                        state_d = (CONSEC == 1) ? ST_FIRED : ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (cmp_match) begin
                        run_d = run_q + 1'b1;
                        if (run_q == RUN_W'(CONSEC - 1)) begin
                            state_d = ST_FIRED;
                        end
                    end else begin
                        run_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
                ST_FIRED: begin
                    state_d = ST_FIRED;
                end
                default: begin
                    state_d = ST_IDLE;
                    run_d   = '0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q        <= 1'b0;
            a1_q        <= '0;
            lo1_q       <= '0;
            hi1_q       <= '0;
            mode1_q     <= MODE_EQ;
            out_valid_q <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
            gt_q        <= 1'b0;
            match_q     <= 1'b0;
            hit_cnt_q   <= '0;
            state_q     <= ST_IDLE;
            run_q       <= '0;
        end else begin
            v1_q        <= v1_d;
            a1_q        <= a1_d;
            lo1_q       <= lo1_d;
            hi1_q       <= hi1_d;
            mode1_q     <= mode1_d;
            out_valid_q <= out_valid_d;
            eq_q        <= eq_d;
            lt_q        <= lt_d;
            gt_q        <= gt_d;
            match_q     <= match_d;
            hit_cnt_q   <= hit_cnt_d;
            state_q     <= state_d;
            run_q       <= run_d;
        end
    end

    assign out_valid = out_valid_q;
    assign eq        = eq_q;
    assign lt        = lt_q;
    assign gt        = gt_q;
    assign match     = match_q;
    assign hit_cnt   = hit_cnt_q;
    assign trigger   = (state_q == ST_FIRED);

endmodule
